// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA frame controller slice.
// f_width gives a counter/index width that never collapses to zero bits.
package vga_pkg;

    typedef enum logic [1:0] {
        SEG_FP,
        SEG_SYNC,
        SEG_BP,
        SEG_DISP
    } t_seg;

    typedef enum logic {
        IDLE,
        RUN
    } t_fc_state;

    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_H_DISP = 640;

    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;
    localparam int VGA_V_DISP = 480;

    function automatic int f_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOT-1 in FP, SYNC, BP, DISP order and reports
// the current segment and the last-position flag used for wrapping.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int   FP   = 16,
    parameter int   SYNC = 96,
    parameter int   BP   = 48,
    parameter int   DISP = 640,
    localparam int  TOT  = FP + SYNC + BP + DISP,
    localparam int  W    = f_width(TOT)
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    input  logic         clear,
    output logic [W-1:0] cnt,
    output t_seg         seg,
    output logic         wrap
);

    localparam logic [W-1:0] SYNC_START = W'(FP);
    localparam logic [W-1:0] BP_START   = W'(FP + SYNC);
    localparam logic [W-1:0] DISP_START = W'(FP + SYNC + BP);
    localparam logic [W-1:0] LAST       = W'(TOT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (step) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        seg = SEG_DISP;
        if (cnt_q < SYNC_START) begin
            seg = SEG_FP;
        end else if (cnt_q < BP_START) begin
            seg = SEG_SYNC;
        end else if (cnt_q < DISP_START) begin
            seg = SEG_BP;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = (cnt_q == LAST);

endmodule

// File: rtl/vga_frame_controller.sv
// Raster sequencer: pixel-enable divider, h/v timing, per-pixel request handshake
// and pe-registered sync/blank/RGB outputs; starts and stops only on frame boundaries.
module vga_frame_controller
    import vga_pkg::*;
#(
    parameter int               CLK_DIV   = 4,
    parameter int               H_FP      = VGA_H_FP,
    parameter int               H_SYNC    = VGA_H_SYNC,
    parameter int               H_BP      = VGA_H_BP,
    parameter int               H_DISP    = VGA_H_DISP,
    parameter int               V_FP      = VGA_V_FP,
    parameter int               V_SYNC    = VGA_V_SYNC,
    parameter int               V_BP      = VGA_V_BP,
    parameter int               V_DISP    = VGA_V_DISP,
    parameter bit               HSYNC_POL = 1'b0,
    parameter bit               VSYNC_POL = 1'b0,
    parameter int               RGB_W     = 12,
    parameter logic [RGB_W-1:0] UF_COLOUR = '0
)(
    input  logic                        i_clk,
    input  logic                        i_resetn,
    input  logic                        i_enable,
    input  logic                        i_clr_underflow,
    input  logic [RGB_W-1:0]            i_px_data,
    input  logic                        i_px_valid,
    output logic                        o_px_req,
    output logic [f_width(H_DISP)-1:0]  o_px_x,
    output logic [f_width(V_DISP)-1:0]  o_px_y,
    output logic                        o_hsync,
    output logic                        o_vsync,
    output logic                        o_blank,
    output logic [RGB_W-1:0]            o_rgb,
    output logic                        o_frame_start,
    output logic                        o_line_start,
    output logic                        o_busy,
    output logic                        o_underflow
);

    localparam int H_TOT = H_FP + H_SYNC + H_BP + H_DISP;
    localparam int V_TOT = V_FP + V_SYNC + V_BP + V_DISP;
    localparam int HW    = f_width(H_TOT);
    localparam int VW    = f_width(V_TOT);
    localparam int XW    = f_width(H_DISP);
    localparam int YW    = f_width(V_DISP);
    localparam int DIV_W = f_width(CLK_DIV);

    localparam logic [HW-1:0]    H_OFF    = HW'(H_FP + H_SYNC + H_BP);
    localparam logic [VW-1:0]    V_OFF    = VW'(V_FP + V_SYNC + V_BP);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pe;
    t_fc_state        state_q, state_d;

    logic [HW-1:0]    hcnt;
    logic [VW-1:0]    vcnt;
    t_seg             hseg, vseg;
    logic             hwrap, vwrap;
    logic             running, active, h_step, v_step;

    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             blank_q, blank_d;
    logic             uf_q, uf_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    // Free-running divider; with CLK_DIV=1 it stays at 0 and pe is constant 1.
    assign pe    = (div_q == DIV_LAST);
    assign div_d = pe ? '0 : div_q + DIV_W'(1);

    assign running = (state_q == RUN);
    assign h_step  = pe & running;
    assign v_step  = pe & running & hwrap;

    vga_axis_counter #(
        .FP   (H_FP),
        .SYNC (H_SYNC),
        .BP   (H_BP),
        .DISP (H_DISP)
    ) u_hcnt (
        .clk   (i_clk),
        .rst_n (i_resetn),
        .step  (h_step),
        .clear (!running),
        .cnt   (hcnt),
        .seg   (hseg),
        .wrap  (hwrap)
    );

    vga_axis_counter #(
        .FP   (V_FP),
        .SYNC (V_SYNC),
        .BP   (V_BP),
        .DISP (V_DISP)
    ) u_vcnt (
        .clk   (i_clk),
        .rst_n (i_resetn),
        .step  (v_step),
        .clear (!running),
        .cnt   (vcnt),
        .seg   (vseg),
        .wrap  (vwrap)
    );

    // i_enable only matters on the IDLE pe and on the last pe of a frame.
    always_comb begin
        state_d = state_q;
        if (pe) begin
            case (state_q)
                IDLE:    if (i_enable) state_d = RUN;
                RUN:     if (hwrap && vwrap && !i_enable) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign active = running && (hseg == SEG_DISP) && (vseg == SEG_DISP);

    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        blank_d = blank_q;
        rgb_d   = rgb_q;
        if (pe) begin
            hsync_d = (running && hseg == SEG_SYNC) ? HSYNC_POL : !HSYNC_POL;
            vsync_d = (running && vseg == SEG_SYNC) ? VSYNC_POL : !VSYNC_POL;
            blank_d = !active;
            rgb_d   = '0;
            if (active) begin
                rgb_d = i_px_valid ? i_px_data : UF_COLOUR;
            end
        end
    end

    // A new underflow wins over a clear arriving in the same cycle.
    always_comb begin
        uf_d = uf_q;
        if (i_clr_underflow) uf_d = 1'b0;
        if (o_px_req && !i_px_valid) uf_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            div_q   <= '0;
            state_q <= IDLE;
            hsync_q <= !HSYNC_POL;
            vsync_q <= !VSYNC_POL;
            blank_q <= 1'b1;
            rgb_q   <= '0;
            uf_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            state_q <= state_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            blank_q <= blank_d;
            rgb_q   <= rgb_d;
            uf_q    <= uf_d;
        end
    end

    assign o_px_req      = pe & active;
    assign o_px_x        = active ? XW'(hcnt - H_OFF) : '0;
    assign o_px_y        = active ? YW'(vcnt - V_OFF) : '0;
    assign o_line_start  = pe & running & (hcnt == '0);
    assign o_frame_start = o_line_start & (vcnt == '0);
    assign o_busy        = running;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_blank       = blank_q;
    assign o_rgb         = rgb_q;
    assign o_underflow   = uf_q;

endmodule

// File: tb/tb_vga_frame_controller.sv
// Bench for vga_frame_controller on a 10x7 raster (4x3 visible): scoreboarded pixel
// stream, sync/frame timing, underflow, frame-boundary stop, async reset, CLK_DIV=1 copy.
module tb_vga_frame_controller;

    localparam int RGB_W = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, en, clr_uf, uf_inject;
    logic             px_valid, px_req, hs, vs, blank, fs, ls, busy, uf;
    logic [RGB_W-1:0] px_data, rgb;
    logic [1:0]       px_x, px_y;

    logic             rst1_n, en1;
    logic             px_req1, hs1, vs1, blank1, fs1, ls1, busy1, uf1;
    logic [RGB_W-1:0] px_data1, rgb1;
    logic [1:0]       px_x1, px_y1;

    // Source model: answers each request with x + 4*y, or withholds (2,1) on demand.
    assign px_data  = {8'd0, px_y, px_x};
    assign px_valid = !(uf_inject && px_x == 2'd2 && px_y == 2'd1);
    assign px_data1 = {8'd0, px_y1, px_x1};

    vga_frame_controller #(
        .CLK_DIV(2), .H_FP(2), .H_SYNC(3), .H_BP(1), .H_DISP(4),
        .V_FP(1), .V_SYNC(2), .V_BP(1), .V_DISP(3),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .RGB_W(RGB_W), .UF_COLOUR('0)
    ) dut (
        .i_clk(clk), .i_resetn(rst_n), .i_enable(en), .i_clr_underflow(clr_uf),
        .i_px_data(px_data), .i_px_valid(px_valid), .o_px_req(px_req),
        .o_px_x(px_x), .o_px_y(px_y), .o_hsync(hs), .o_vsync(vs), .o_blank(blank),
        .o_rgb(rgb), .o_frame_start(fs), .o_line_start(ls), .o_busy(busy),
        .o_underflow(uf)
    );

    vga_frame_controller #(
        .CLK_DIV(1), .H_FP(2), .H_SYNC(3), .H_BP(1), .H_DISP(4),
        .V_FP(1), .V_SYNC(2), .V_BP(1), .V_DISP(3),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .RGB_W(RGB_W), .UF_COLOUR('0)
    ) dut1 (
        .i_clk(clk), .i_resetn(rst1_n), .i_enable(en1), .i_clr_underflow(1'b0),
        .i_px_data(px_data1), .i_px_valid(1'b1), .o_px_req(px_req1),
        .o_px_x(px_x1), .o_px_y(px_y1), .o_hsync(hs1), .o_vsync(vs1), .o_blank(blank1),
        .o_rgb(rgb1), .o_frame_start(fs1), .o_line_start(ls1), .o_busy(busy1),
        .o_underflow(uf1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard and timing monitor for the CLK_DIV=2 instance.
    logic [RGB_W-1:0] sb_q[$];
    int  cyc = 0, fs_cyc = 0, req_idx = 0, ls_cnt = 0, hrun = 0, vrun = 0, frames = 0;
    bit  fs_prev_valid = 0, frame_seen = 0;

    always @(negedge clk) begin
        int ex_x, ex_y;
        logic [RGB_W-1:0] exp_rgb;
        cyc++;
        if (!rst_n) begin
            sb_q.delete();
            fs_prev_valid = 0; frame_seen = 0;
            hrun = 0; vrun = 0; req_idx = 0; ls_cnt = 0;
        end else begin
            if (sb_q.size() != 0) begin
                exp_rgb = sb_q.pop_front();
                chk("rgb_pixel", 32'(rgb), 32'(exp_rgb));
                chk("blank_active", 32'(blank), 0);
            end else if (blank) begin
                chk("rgb_blanked", 32'(rgb), 0);
            end
            if (fs) begin
                if (frame_seen) begin
                    chk("reqs_per_frame", req_idx, 12);
                    chk("lines_per_frame", ls_cnt, 7);
                end
                if (fs_prev_valid) chk("frame_period_clk", cyc - fs_cyc, 140);
                $display("frame %0d start at cycle %0d", frames, cyc);
                frames++;
                fs_cyc = cyc; fs_prev_valid = 1; frame_seen = 1;
                req_idx = 0; ls_cnt = 0;
            end
            if (ls) ls_cnt++;
            if (px_req) begin
                ex_x = req_idx % 4;
                ex_y = req_idx / 4;
                chk("px_x", 32'(px_x), ex_x);
                chk("px_y", 32'(px_y), ex_y);
                exp_rgb = (uf_inject && ex_x == 2 && ex_y == 1) ? '0 : RGB_W'(ex_x + 4 * ex_y);
                sb_q.push_back(exp_rgb);
                req_idx++;
            end
            if (!hs) hrun++;
            else if (hrun != 0) begin chk("hsync_low_clk", hrun, 6); hrun = 0; end
            if (!vs) vrun++;
            else if (vrun != 0) begin chk("vsync_low_clk", vrun, 40); vrun = 0; end
            if (!busy && frame_seen) begin
                chk("reqs_last_frame", req_idx, 12);
                chk("lines_last_frame", ls_cnt, 7);
                frame_seen = 0; fs_prev_valid = 0;
            end
        end
    end

    // Monitor for the CLK_DIV=1 instance.
    int cyc1 = 0, fs1_cyc = 0, req1_cnt = 0, run1 = 0, frames1 = 0;
    bit fs1_valid = 0;

    always @(negedge clk) begin
        cyc1++;
        if (rst1_n) begin
            if (fs1) begin
                if (fs1_valid) begin
                    chk("frame_period_div1", cyc1 - fs1_cyc, 70);
                    chk("reqs_per_frame_div1", req1_cnt, 12);
                end
                $display("div1 frame %0d start at cycle %0d", frames1, cyc1);
                frames1++;
                fs1_cyc = cyc1; fs1_valid = 1; req1_cnt = 0;
            end
            if (px_req1) begin
                req1_cnt++; run1++;
            end else if (run1 != 0) begin
                chk("req_run_div1", run1, 4);
                run1 = 0;
            end
            if (!busy1) fs1_valid = 0;
        end
    end

    initial begin
        int n;
        rst_n = 0; rst1_n = 0; en = 0; en1 = 0; clr_uf = 0; uf_inject = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_hsync", 32'(hs), 1);
        chk("rst_vsync", 32'(vs), 1);
        chk("rst_blank", 32'(blank), 1);
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_req", 32'(px_req), 0);
        chk("rst_uf", 32'(uf), 0);
        chk("rst_px_x", 32'(px_x), 0);
        rst_n = 1; rst1_n = 1;

        // Idle with enable low: nothing moves.
        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (px_req || busy || !hs || !vs || !blank || fs) n++;
        end
        chk("idle_activity", n, 0);

        // Run both instances for several frames.
        en = 1; en1 = 1;
        repeat (440) @(negedge clk);
        chk("frames_seen_ge3", 32'(frames >= 3), 1);
        chk("frames_div1_ge5", 32'(frames1 >= 5), 1);
        en1 = 0;

        // Underflow at (2,1), sticky, clear, then set+clear in the same cycle.
        n = 0;
        do begin @(negedge clk); n++; end while (!fs && n < 200);
        chk("wait_fs_uf", 32'(n < 200), 1);
        chk("uf_before", 32'(uf), 0);
        uf_inject = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!uf && n < 200);
        chk("uf_set", 32'(uf), 1);
        uf_inject = 0;
        repeat (20) @(negedge clk);
        chk("uf_sticky", 32'(uf), 1);
        clr_uf = 1;
        @(negedge clk);
        clr_uf = 0;
        chk("uf_cleared", 32'(uf), 0);
        uf_inject = 1;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(px_req && px_x == 2'd2 && px_y == 2'd1) && n < 300);
        chk("wait_px_2_1", 32'(n < 300), 1);
        clr_uf = 1;
        @(negedge clk);
        clr_uf = 0; uf_inject = 0;
        chk("uf_set_beats_clr", 32'(uf), 1);

        // Drop enable on the first visible line; frame must finish.
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(px_req && px_x == 2'd0 && px_y == 2'd0) && n < 400);
        chk("wait_row0", 32'(n < 400), 1);
        en = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 200);
        chk("busy_fall_clk", n, 47);
        repeat (10) @(negedge clk);
        chk("idle_stays", 32'(busy), 0);
        en = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!fs && n < 10);
        chk("restart_fs_within_2pe", 32'(n <= 4), 1);

        // Asynchronous reset while an active pixel is on the pins.
        n = 0;
        do begin @(posedge clk); #3; n++; end while (blank && n < 300);
        chk("wait_active", 32'(blank), 0);
        chk("uf_before_rst", 32'(uf), 1);
        rst_n = 0;
        #1;
        chk("arst_blank", 32'(blank), 1);
        chk("arst_rgb", 32'(rgb), 0);
        chk("arst_hsync", 32'(hs), 1);
        chk("arst_vsync", 32'(vs), 1);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_req", 32'(px_req), 0);
        chk("arst_uf", 32'(uf), 0);
        repeat (3) @(negedge clk);
        rst_n = 1;

        // Recovery: one more run that stops cleanly.
        repeat (200) @(negedge clk);
        chk("busy_after_rst", 32'(busy), 1);
        en = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 200);
        chk("final_stop", 32'(busy), 0);
        chk("div1_stopped", 32'(busy1), 0);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
